servo_pwm_driver: RTL
=====================

# servo_pwm_driver

Converts the three 10-bit arm position words (x, y, z) selected by the top-level source mux (memory or accelerometer) into three hobby-servo PWM waveforms for the arm joints. Each channel runs a fixed-period frame; the target is sampled once per frame and approached with an optional per-frame slew limit, so source switches never cause joint jumps. Sits directly downstream of the source mux, in parallel with the display path.

## Interface
- PERIOD_CYCLES, 1_000_000: frame length in clk cycles (20 ms at 50 MHz).
- PULSE_MIN_CYCLES, 50_000: pulse width for position 0 (1 ms).
- STEP_CYCLES, 48: extra pulse cycles per position LSB.
- MAX_STEP, 16: maximum position change per frame (slew limit).
- CENTER_POS, 512: reset position of every channel.
- clk  in  1  system clock (MAX10_CLK1_50 at top level).
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  run PWM; low forces outputs low and freezes state.
- x_target, y_target, z_target  in  10 each  requested positions, unsigned 0..1023.
- pwm_x, pwm_y, pwm_z  out  1 each  servo PWM, registered.
- x_pos, y_pos, z_pos  out  10 each  currently commanded (slewed) positions.
- frame_start  out  1  one-cycle pulse on the first cycle of each frame.
- at_target  out  1  high when all three positions equal their last sampled targets.

## Operation
- frame_cnt counts 0..PERIOD_CYCLES-1, wraps to 0.
- Update cycle = cycle with frame_cnt == PERIOD_CYCLES-1 and enable high. On it, per channel:
  - tgt_q <= target input (only sampling point; targets ignored otherwise).
  - delta = target - pos (signed, 11 bits). |delta| <= MAX_STEP: pos <= target; else pos <= pos ± MAX_STEP toward target.
  - width_q <= PULSE_MIN_CYCLES + new_pos * STEP_CYCLES (unsigned, 20 bits).
- pwm_* high for exactly width_q cycles starting in the frame_start cycle, then low until next frame.
- at_target = (x_pos==x_tgt_q)&&(y_pos==y_tgt_q)&&(z_pos==z_tgt_q), registered with positions.
- Reset: frame_cnt = PERIOD_CYCLES-1, positions = CENTER_POS, tgt_q = CENTER_POS, width_q = PULSE_MIN_CYCLES + CENTER_POS*STEP_CYCLES, pwm_* = 0, frame_start = 0, at_target = 1.
- enable low: next edge pwm_* = 0, frame_start = 0, frame_cnt forced to PERIOD_CYCLES-1, positions/targets/widths held. On re-enable the first cycle is an update cycle; a full frame follows. No partial pulses.
- Target changing on the update cycle: value present on that edge is used. Target equal to pos: no change, at_target high.
- Elaboration check: PULSE_MIN_CYCLES + 1023*STEP_CYCLES < PERIOD_CYCLES, else $error.

## Timing
- Target-to-position latency: up to PERIOD_CYCLES cycles to next update, then 1 edge.
- frame_start and pwm_* rise together one edge after the update cycle (frame_cnt == 0).
- Full-scale move 0->1023 with MAX_STEP=16: 64 frames.
- rst asserted mid-pulse: pwm_* low immediately (async); first frame_start one edge after rst release plus one update cycle.

## Configuration
- SERVO_SLEW_LIMIT_EN defined: slew limiting as above.
- Not defined: update cycle loads pos <= target directly (MAX_STEP ignored); at_target high after every update cycle.

## Structure
- Shared package servo_pkg: POS_WIDTH=10, CNT_WIDTH=20, default CENTER_POS, function pos_to_width(pos).
- Sub-module servo_channel: one per axis (target sample, slew, width, compare against shared frame_cnt); top holds frame counter, frame_start, at_target AND.

## Test plan
Bench parameters: PERIOD_CYCLES=4096, PULSE_MIN_CYCLES=1024, STEP_CYCLES=2, MAX_STEP=16, CENTER_POS=512, SERVO_SLEW_LIMIT_EN defined.
- Reset, enable=1, targets=512 -> first frame_start 1 cycle after update cycle; pwm_* high 2048 cycles, low 2048; at_target=1.
- x_target=1023 held -> x_pos 528, 544, ... reaches 1023 after 32 frames; final pwm_x width 3070; at_target low until then.
- y_target=0 then switch to 600 mid-frame, 5 frames later -> y_pos 496,480,...,432 then rises 448,464,...; only update-cycle value used.
- enable low mid-pulse -> pwm_* low next edge, positions frozen; re-enable -> frame_start after one update cycle, full-width pulse.
- rst asserted during pulse -> pwm_* low asynchronously; after release all positions 512, widths 2048.
- Build without SERVO_SLEW_LIMIT_EN, z_target 0->1023 -> z_pos 1023 after one update, pwm_z width 3070 next frame.

Source files
------------

// File: rtl/servo_pkg.sv
// servo_pkg
//   Shared types and constants for the servo PWM driver slice.
//   POS_WIDTH  : width of a joint position word (0..1023)
//   CNT_WIDTH  : width of the frame counter and pulse widths
//   pos_to_width() maps a position to its pulse width in clk cycles.
package servo_pkg;

    localparam int POS_WIDTH      = 10;
    localparam int CNT_WIDTH      = 20;
    localparam int CENTER_POS_DEF = 512;
    localparam int PULSE_MIN_DEF  = 50_000;
    localparam int STEP_DEF       = 48;

    typedef logic [POS_WIDTH-1:0] pos_t;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    function automatic cnt_t pos_to_width(input pos_t pos,
                                          input int   pulse_min = PULSE_MIN_DEF,
                                          input int   step      = STEP_DEF);
        return cnt_t'(pulse_min + int'(pos) * step);
    endfunction

endpackage

// File: rtl/servo_pwm_driver_if.sv
// servo_pwm_driver_if
//   Bundles the run control, the three target words and all driver outputs.
//   master : drives enable and targets, observes PWM/positions/status
//   slave  : the driver itself
interface servo_pwm_driver_if
    import servo_pkg::*;
();
    logic enable;
    pos_t x_target;
    pos_t y_target;
    pos_t z_target;
    logic pwm_x;
    logic pwm_y;
    logic pwm_z;
    pos_t x_pos;
    pos_t y_pos;
    pos_t z_pos;
    logic frame_start;
    logic at_target;

    modport master (
        output enable, x_target, y_target, z_target,
        input  pwm_x, pwm_y, pwm_z, x_pos, y_pos, z_pos, frame_start, at_target
    );

    modport slave (
        input  enable, x_target, y_target, z_target,
        output pwm_x, pwm_y, pwm_z, x_pos, y_pos, z_pos, frame_start, at_target
    );
endinterface

// File: rtl/servo_channel.sv
// servo_channel
//   One servo axis: samples its target on the update cycle, steps the
//   commanded position toward it, recomputes the pulse width and drives a
//   registered PWM bit by comparing against the shared frame counter.
//   Build option SERVO_SLEW_LIMIT_EN: when defined, each update moves at
//   most MAX_STEP toward the target; otherwise the target is taken directly.
//   Ports: clk, rst (async, active-high), enable, update (last frame cycle
//   while enabled), cnt_next (frame counter value for the next cycle),
//   target in; pwm, pos, at_tgt out.
module servo_channel
    import servo_pkg::*;
#(
    parameter int PULSE_MIN_CYCLES = PULSE_MIN_DEF,
    parameter int STEP_CYCLES      = STEP_DEF,
    parameter int MAX_STEP         = 16,
    parameter int CENTER_POS       = CENTER_POS_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic update,
    input  cnt_t cnt_next,
    input  pos_t target,
    output logic pwm,
    output pos_t pos,
    output logic at_tgt
);

    pos_t tgt_q;
    pos_t pos_new;
    cnt_t width_q;
    cnt_t width_new;

    if (MAX_STEP < 1 || MAX_STEP >= (1 << POS_WIDTH)) begin : g_bad_step
        $error("servo_channel: MAX_STEP out of range");
    end

`ifdef SERVO_SLEW_LIMIT_EN
    localparam logic signed [POS_WIDTH:0] LIMIT = (POS_WIDTH+1)'(MAX_STEP);
    logic signed [POS_WIDTH:0] delta;

    // Overshoot is impossible: a step is only taken when the target lies
    // strictly beyond it, so pos +/- MAX_STEP stays inside 0..1023.
    always_comb begin
        delta   = $signed({1'b0, target}) - $signed({1'b0, pos});
        pos_new = target;
        if (delta > LIMIT) begin
            pos_new = pos + pos_t'(MAX_STEP);
        end else if (delta < -LIMIT) begin
            pos_new = pos - pos_t'(MAX_STEP);
        end
    end
`else
    assign pos_new = target;
`endif

    assign width_new = pos_to_width(pos_new, PULSE_MIN_CYCLES, STEP_CYCLES);
    assign at_tgt    = (pos == tgt_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos     <= pos_t'(CENTER_POS);
            tgt_q   <= pos_t'(CENTER_POS);
            width_q <= pos_to_width(pos_t'(CENTER_POS), PULSE_MIN_CYCLES, STEP_CYCLES);
            pwm     <= 1'b0;
        end else if (!enable) begin
            pwm <= 1'b0;
        end else begin
            if (update) begin
                tgt_q   <= target;
                pos     <= pos_new;
                width_q <= width_new;
            end
            // The first pulse of a frame already uses the freshly computed width.
            pwm <= (cnt_next < (update ? width_new : width_q));
        end
    end

endmodule

// File: rtl/servo_pwm_driver.sv
// servo_pwm_driver
//   Three-axis hobby-servo PWM generator. Holds the shared frame counter,
//   the frame_start pulse and the all-axes at_target flag; each axis is a
//   servo_channel. Build option SERVO_SLEW_LIMIT_EN enables per-frame slew
//   limiting inside the channels.
//   Ports: clk, rst (async, active-high), bus (servo_pwm_driver_if.slave:
//   enable, x/y/z_target in; pwm_x/y/z, x/y/z_pos, frame_start, at_target out).
module servo_pwm_driver
    import servo_pkg::*;
#(
    parameter int PERIOD_CYCLES    = 1_000_000,
    parameter int PULSE_MIN_CYCLES = 50_000,
    parameter int STEP_CYCLES      = 48,
    parameter int MAX_STEP         = 16,
    parameter int CENTER_POS       = CENTER_POS_DEF
) (
    input logic               clk,
    input logic               rst,
    servo_pwm_driver_if.slave bus
);

    localparam cnt_t LAST = cnt_t'(PERIOD_CYCLES - 1);

    if (PULSE_MIN_CYCLES + 1023 * STEP_CYCLES >= PERIOD_CYCLES) begin : g_bad_width
        $error("servo_pwm_driver: full-scale pulse does not fit in the frame");
    end
    if (PERIOD_CYCLES > (1 << CNT_WIDTH)) begin : g_bad_period
        $error("servo_pwm_driver: PERIOD_CYCLES exceeds the frame counter");
    end

    cnt_t frame_cnt;
    cnt_t cnt_next;
    logic update;
    logic frame_start_q;
    logic at_x;
    logic at_y;
    logic at_z;

    assign update = bus.enable && (frame_cnt == LAST);

    // Parking the counter on LAST while disabled makes the first enabled
    // cycle an update cycle, so a re-enable always starts a whole frame.
    always_comb begin
        cnt_next = LAST;
        if (bus.enable) begin
            cnt_next = (frame_cnt == LAST) ? '0 : frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt     <= LAST;
            frame_start_q <= 1'b0;
        end else begin
            frame_cnt     <= cnt_next;
            frame_start_q <= update;
        end
    end

    assign bus.frame_start = frame_start_q;
    assign bus.at_target   = at_x & at_y & at_z;

    servo_channel #(
        .PULSE_MIN_CYCLES(PULSE_MIN_CYCLES), .STEP_CYCLES(STEP_CYCLES),
        .MAX_STEP(MAX_STEP), .CENTER_POS(CENTER_POS)
    ) u_ch_x (
        .clk(clk), .rst(rst), .enable(bus.enable), .update(update), .cnt_next(cnt_next),
        .target(bus.x_target), .pwm(bus.pwm_x), .pos(bus.x_pos), .at_tgt(at_x)
    );

    servo_channel #(
        .PULSE_MIN_CYCLES(PULSE_MIN_CYCLES), .STEP_CYCLES(STEP_CYCLES),
        .MAX_STEP(MAX_STEP), .CENTER_POS(CENTER_POS)
    ) u_ch_y (
        .clk(clk), .rst(rst), .enable(bus.enable), .update(update), .cnt_next(cnt_next),
        .target(bus.y_target), .pwm(bus.pwm_y), .pos(bus.y_pos), .at_tgt(at_y)
    );

    servo_channel #(
        .PULSE_MIN_CYCLES(PULSE_MIN_CYCLES), .STEP_CYCLES(STEP_CYCLES),
        .MAX_STEP(MAX_STEP), .CENTER_POS(CENTER_POS)
    ) u_ch_z (
        .clk(clk), .rst(rst), .enable(bus.enable), .update(update), .cnt_next(cnt_next),
        .target(bus.z_target), .pwm(bus.pwm_z), .pos(bus.z_pos), .at_tgt(at_z)
    );

endmodule
